// File: rtl/bram_burst_reader.sv
// bram_burst_reader: walks a BRAM address range one read at a time and streams each word out on valid/ready.
// A request is issued only after the previous beat has been accepted, so there is never more than one read outstanding.
module bram_burst_reader #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 31,
    parameter int LEN_WIDTH  = 16,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    input  logic                  bram_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, DONE, ERR} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [LEN_WIDTH-1:0]    remaining;
    logic [TW-1:0]           timer;
    logic                    timeout;
    logic                    last_word;

    assign timeout   = timer == TW'(TIMEOUT - 1);
    assign last_word = remaining == LEN_WIDTH'(1);
    assign bram_we   = 1'b0;
    assign bram_din  = '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length != '0) ? ISSUE : DONE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = bram_valid ? HOLD : (timeout ? ERR : WAIT);
            HOLD:    if (out_ready) state_nxt = last_word ? DONE : ISSUE;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        done      = state == DONE;
        bram_en   = state == ISSUE;
        out_valid = state == HOLD;
        bram_addr = (state == ISSUE) ? cur_addr : '0;
    end

    // Data path; a valid strobe arriving together with the timeout wins because it is tested first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr  <= '0;
            remaining <= '0;
            timer     <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
            error     <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                error <= 1'b0;
                if (length != '0) begin
                    cur_addr  <= base_addr;
                    remaining <= length;
                end
            end
            if (state == ISSUE) timer <= '0;
            if (state == WAIT) begin
                if (bram_valid) begin
                    out_data <= bram_dout;
                    out_last <= last_word;
                end else if (timeout) begin
                    error <= 1'b1;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
            if (state == HOLD && out_ready) begin
                out_last <= 1'b0;
                if (!last_word) begin
                    cur_addr  <= cur_addr + ADDR_WIDTH'(1);
                    remaining <= remaining - LEN_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: doc/bram_burst_reader.md
Name: bram_burst_reader

Overview:
- Read-side initiator for the single-port BRAM wrapper. Issues one read request at a time: a one-cycle en=1, we=0 pulse with an address.
- Waits for the wrapper's valid strobe, then forwards the returned word on a valid/ready stream.
- Walks a contiguous address range (base, length) per start command. Sits between a control block (start/done/error) and a downstream consumer.

Parameters:
- ADDR_WIDTH, 15, BRAM address width; wrapper addr port width.
- DATA_WIDTH, 31, BRAM word width; wrapper din/dout width.
- LEN_WIDTH, 16, width of the burst length field (words).
- TIMEOUT, 8, maximum WAIT cycles for bram_valid before error; must be ≥ 2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  burst command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; latched on accepted start.
- length  in  LEN_WIDTH  number of words; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at burst completion.
- error  out  1  sticky timeout flag; cleared by the next accepted start.
- bram_addr  out  ADDR_WIDTH  request address to the wrapper.
- bram_en  out  1  request strobe to the wrapper.
- bram_we  out  1  constant 0.
- bram_din  out  DATA_WIDTH  constant 0.
- bram_dout  in  DATA_WIDTH  read data from the wrapper.
- bram_valid  in  1  read data valid from the wrapper.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_last  out  1  high with the final beat of a burst.

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: busy, done, error, bram_addr, bram_en, out_data, out_valid, out_last. Internal address, remaining count and timer are 0. Reset mid-burst abandons the burst with no done pulse.
- States: IDLE, ISSUE, WAIT, HOLD, DONE, ERR. All outputs are registered or decoded from state only. Nothing is combinational from inputs.
- IDLE:
  - start=1 and length≠0: latch cur_addr=base_addr and remaining=length, clear error, go to ISSUE.
  - start=1 and length=0: clear error, go to DONE (no BRAM access).
  - bram_valid in IDLE is ignored.
- ISSUE: bram_en=1, bram_addr=cur_addr for exactly one cycle. Clear timer. Go to WAIT.
- WAIT: bram_en=0.
  - bram_valid=1: capture bram_dout into out_data, set out_last=(remaining==1), go to HOLD.
  - Otherwise timer+1. When timer reaches TIMEOUT-1 with no valid, go to ERR.
  - If valid and the timeout coincide, valid wins.
- HOLD: out_valid=1; out_data/out_last stable while out_ready=0.
  - On out_ready=1: if remaining==1, go to DONE. Otherwise cur_addr+1 (wraps modulo 2^ADDR_WIDTH, e.g. 0x7FFF→0x0000), remaining-1, go to ISSUE.
  - out_valid drops the cycle after the handshake.
- DONE: done=1 for one cycle, then IDLE.
- ERR: error set to 1 (sticky), out_valid=0, then IDLE next cycle. No done pulse.
- start while busy is ignored entirely; no queuing.
- Latency: start at cycle 0 → bram_en at cycle 1. Wrapper valid at cycle 1+L → out_valid at cycle 2+L. With out_ready held high, each beat takes L+2 cycles.
- Only one outstanding request at a time. The next bram_en is never issued before the current beat is accepted.

Test Plan:
- Wrapper model L=3, base=0x0010, length=4, out_ready=1 → bram_en pulses at addresses 0x10–0x13. Beats 5 cycles apart, out_last on the 4th beat only. done one cycle after the last handshake; busy low afterwards.
- Same burst with out_ready toggling 1-0-0-1 → data held stable while stalled. No second bram_en until the handshake. No beat lost or duplicated.
- base=0x7FFE, length=3 → requested addresses 0x7FFE, 0x7FFF, 0x0000.
- length=0 with start → done pulses at cycle 1, bram_en never asserted, out_valid never asserted.
- Model withholds bram_valid → error rises after 8 WAIT cycles, no done, back to IDLE. The next start with length=1 clears error and completes normally.
- Assert rst mid-WAIT, then release while a late bram_valid arrives → outputs 0, state IDLE, stale valid ignored. A start issued during busy has no effect.
